// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_pkg
// Description : Shared encodings and constants for the MEM/WB boundary stage:
//               load width codes, reset/bubble values and a lane-extend
//               helper used by the load-extend unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

  // DataWidth_M encodings
  localparam logic [1:0] WIDTH_WORD = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_BYTE = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  // Values loaded into the W control registers on reset
  localparam logic RST_VALID     = 1'b0;
  localparam logic RST_REGWRITE  = 1'b0;
  localparam logic RST_ALIGNERR  = 1'b0;

  // Values loaded into the W control registers when a bubble is inserted
  localparam logic BUBBLE_VALID    = 1'b0;
  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_ALIGNERR = 1'b0;

  // Extend a selected byte (lane[7:0]) or halfword (lane[15:0]) to 32 bits.
  // For a byte, the upper half of the lane argument is ignored.
  function automatic logic [31:0] extendLane(input logic [15:0] lane,
                                             input logic        isHalf,
                                             input logic        isUnsigned);
    logic fill;
    fill = isUnsigned ? 1'b0 : (isHalf ? lane[15] : lane[7]);
    if (isHalf) begin
      extendLane = {{16{fill}}, lane};
    end else begin
      extendLane = {{24{fill}}, lane[7:0]};
    end
  endfunction

endpackage : mem_wb_stage_pkg
`default_nettype wire

// File: rtl/mem_wb_stage_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage_load_extend
// Description : Combinational load lane selection, sign/zero extension and
//               width/offset misalignment detection for the MEM/WB stage.
//               The misalign output reflects width and offset only; the
//               caller qualifies it with whether the instruction is a load.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage_load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] word,
  input  logic [1:0]    offset,
  input  logic [1:0]    width,
  input  logic          isUnsigned,
  output logic [DW-1:0] data,
  output logic          misalign
);

  logic [7:0]  wByte;
  logic [15:0] wHalf;

  // Pick the addressed byte and halfword lanes out of the aligned word
  always_comb begin
    wByte = word[7:0];
    case (offset)
      2'd0:    wByte = word[7:0];
      2'd1:    wByte = word[15:8];
      2'd2:    wByte = word[23:16];
      default: wByte = word[31:24];
    endcase
    wHalf = offset[1] ? word[31:16] : word[15:0];
  end

  // Extend the selected lane and flag width/offset combinations that are illegal
  always_comb begin
    data     = word;
    misalign = 1'b0;
    case (width)
      WIDTH_BYTE: begin
        data = extendLane({8'h00, wByte}, 1'b0, isUnsigned);
      end
      WIDTH_HALF: begin
        data     = extendLane(wHalf, 1'b1, isUnsigned);
        misalign = offset[0];
      end
      WIDTH_WORD: begin
        data     = word;
        misalign = (offset != 2'b00);
      end
      default: begin
        // Reserved width: always an error, data is discarded by the caller
        data     = word;
        misalign = 1'b1;
      end
    endcase
  end

endmodule : mem_wb_stage_load_extend
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_stage
// Description : MEM/WB pipeline boundary. Registers MEM-stage results,
//               extracts/extends load lanes, selects write-back data, flags
//               misaligned loads and counts retired instructions. Every
//               output is driven straight from a register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 32
) (
  input  logic            Clk,
  input  logic            Rst,
  input  logic            Stall,
  input  logic            Flush,
  input  logic            Valid_M,
  input  logic            RegWrite_M,
  input  logic            MemtoReg_M,
  input  logic            MemRead_M,
  input  logic [1:0]      DataWidth_M,
  input  logic            LoadUnsigned_M,
  input  logic [DW-1:0]   ALUResult_M,
  input  logic [DW-1:0]   DataMem_out,
  input  logic [RW-1:0]   WriteReg_M,
  output logic            Valid_W,
  output logic            RegWrite_W,
  output logic [RW-1:0]   WriteReg_W,
  output logic [DW-1:0]   WriteData_W,
  output logic            AlignErr_W,
  output logic [CNTW-1:0] RetireCount
);

  // W-stage registers
  logic            rValid;
  logic            rRegWrite;
  logic [RW-1:0]   rWriteReg;
  logic [DW-1:0]   rWriteData;
  logic            rAlignErr;
  logic [CNTW-1:0] rRetireCount;

  // Next-state values for a normal (non-stalled, non-flushed) load
  logic [DW-1:0]   wLoadData;
  logic            wLaneMisalign;
  logic            wMisalign;
  logic            wRegWrite;
  logic [DW-1:0]   wWriteData;
  logic            wRetire;

  mem_wb_stage_load_extend #(
    .DW (DW)
  ) u_load_extend (
    .word       (DataMem_out),
    .offset     (ALUResult_M[1:0]),
    .width      (DataWidth_M),
    .isUnsigned (LoadUnsigned_M),
    .data       (wLoadData),
    .misalign   (wLaneMisalign)
  );

  // Only a load that writes back from memory is subject to the alignment check;
  // the ALU path passes through untouched.
  assign wMisalign  = MemRead_M & MemtoReg_M & wLaneMisalign;
  // Register 0 is hard-wired, so a write to it is suppressed here.
  assign wRegWrite  = RegWrite_M & Valid_M & ~wMisalign & (WriteReg_M != '0);
  assign wWriteData = wMisalign ? '0 : (MemtoReg_M ? wLoadData : ALUResult_M);
  assign wRetire    = ~Flush & ~Stall & Valid_M;

  // Pipeline registers: reset, then bubble on flush, then hold on stall
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rValid     <= RST_VALID;
      rRegWrite  <= RST_REGWRITE;
      rWriteReg  <= '0;
      rWriteData <= '0;
      rAlignErr  <= RST_ALIGNERR;
    end else if (Flush) begin
      rValid     <= BUBBLE_VALID;
      rRegWrite  <= BUBBLE_REGWRITE;
      rWriteReg  <= '0;
      rWriteData <= '0;
      rAlignErr  <= BUBBLE_ALIGNERR;
    end else if (!Stall) begin
      rValid     <= Valid_M;
      rRegWrite  <= wRegWrite;
      rWriteReg  <= WriteReg_M;
      rWriteData <= wWriteData;
      rAlignErr  <= wMisalign;
    end
  end

  // Retire counter: counts valid instructions entering W, wraps silently
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rRetireCount <= '0;
    end else if (wRetire) begin
      rRetireCount <= rRetireCount + CNTW'(1);
    end
  end

  assign Valid_W     = rValid;
  assign RegWrite_W  = rRegWrite;
  assign WriteReg_W  = rWriteReg;
  assign WriteData_W = rWriteData;
  assign AlignErr_W  = rAlignErr;
  assign RetireCount = rRetireCount;

endmodule : mem_wb_stage
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage. A behavioural model of
//               the W-stage state is stepped alongside the DUT; a second
//               instance with a 4-bit counter exercises counter wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

  logic        Clk = 1'b0;
  logic        Rst, Stall, Flush, Valid_M, RegWrite_M, MemtoReg_M, MemRead_M;
  logic        LoadUnsigned_M;
  logic [1:0]  DataWidth_M;
  logic [31:0] ALUResult_M, DataMem_out;
  logic [4:0]  WriteReg_M;

  logic        Valid_W, RegWrite_W, AlignErr_W;
  logic [4:0]  WriteReg_W;
  logic [31:0] WriteData_W, RetireCount;

  logic        w4Valid, w4RegWrite, w4AlignErr;
  logic [4:0]  w4WriteReg;
  logic [31:0] w4WriteData;
  logic [3:0]  w4Count;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic        eValid, eRegWrite, eAlign;
  logic [4:0]  eWriteReg;
  logic [31:0] eWriteData, eCount;

  wire [71:0] gotAll = {Valid_W, RegWrite_W, WriteReg_W, WriteData_W, AlignErr_W, RetireCount};
  wire [71:0] expAll = {eValid, eRegWrite, eWriteReg, eWriteData, eAlign, eCount};

  mem_wb_stage dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Valid_M(Valid_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .MemRead_M(MemRead_M),
    .DataWidth_M(DataWidth_M), .LoadUnsigned_M(LoadUnsigned_M),
    .ALUResult_M(ALUResult_M), .DataMem_out(DataMem_out), .WriteReg_M(WriteReg_M),
    .Valid_W(Valid_W), .RegWrite_W(RegWrite_W), .WriteReg_W(WriteReg_W),
    .WriteData_W(WriteData_W), .AlignErr_W(AlignErr_W), .RetireCount(RetireCount)
  );

  mem_wb_stage #(.CNTW(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Flush(Flush), .Valid_M(Valid_M),
    .RegWrite_M(RegWrite_M), .MemtoReg_M(MemtoReg_M), .MemRead_M(MemRead_M),
    .DataWidth_M(DataWidth_M), .LoadUnsigned_M(LoadUnsigned_M),
    .ALUResult_M(ALUResult_M), .DataMem_out(DataMem_out), .WriteReg_M(WriteReg_M),
    .Valid_W(w4Valid), .RegWrite_W(w4RegWrite), .WriteReg_W(w4WriteReg),
    .WriteData_W(w4WriteData), .AlignErr_W(w4AlignErr), .RetireCount(w4Count)
  );

  always #5 Clk = ~Clk;

  // Loaded value computed by shifting the aligned word down to the addressed lane
  function automatic logic [31:0] refLoad(input logic [31:0] dm, input logic [1:0] off,
                                          input logic [1:0] w, input logic uns);
    logic [31:0] sh;
    if (w == 2'b10) begin
      sh = (dm >> (8 * off)) & 32'h0000_00FF;
      if (!uns && sh[7]) sh = sh | 32'hFFFF_FF00;
      return sh;
    end else if (w == 2'b01) begin
      sh = (dm >> (16 * off[1])) & 32'h0000_FFFF;
      if (!uns && sh[15]) sh = sh | 32'hFFFF_0000;
      return sh;
    end
    return dm;
  endfunction

  function automatic logic refMis(input logic rd, input logic m2r,
                                  input logic [1:0] w, input logic [1:0] off);
    if (!(rd && m2r)) return 1'b0;
    return (w == 2'b11) || (w == 2'b01 && off % 2 == 1) || (w == 2'b00 && off != 0);
  endfunction

  // Advance the reference model by one edge using the current inputs, then clock the DUT
  task automatic tick();
    logic mis;
    if (Rst) begin
      {eValid, eRegWrite, eWriteReg, eWriteData, eAlign, eCount} = '0;
    end else if (Flush) begin
      {eValid, eRegWrite, eWriteReg, eWriteData, eAlign} = '0;
    end else if (!Stall) begin
      mis        = refMis(MemRead_M, MemtoReg_M, DataWidth_M, ALUResult_M[1:0]);
      eValid     = Valid_M;
      eRegWrite  = RegWrite_M && Valid_M && !mis && (WriteReg_M != 0);
      eWriteReg  = WriteReg_M;
      eAlign     = mis;
      eWriteData = mis ? 32'h0 : (MemtoReg_M ? refLoad(DataMem_out, ALUResult_M[1:0],
                                                        DataWidth_M, LoadUnsigned_M)
                                             : ALUResult_M);
      if (Valid_M) eCount = eCount + 1;
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic setLoad(input logic [31:0] dm, input logic [31:0] addr, input logic [1:0] w,
                         input logic uns, input logic [4:0] rd);
    Valid_M = 1; RegWrite_M = 1; MemtoReg_M = 1; MemRead_M = 1;
    DataMem_out = dm; ALUResult_M = addr; DataWidth_M = w; LoadUnsigned_M = uns;
    WriteReg_M = rd; Stall = 0; Flush = 0; Rst = 0;
  endtask

  task automatic test_reset();
    Rst = 1; Stall = 0; Flush = 0; Valid_M = 1; RegWrite_M = 1; MemtoReg_M = 0;
    MemRead_M = 0; DataWidth_M = 0; LoadUnsigned_M = 0; ALUResult_M = 32'h5;
    DataMem_out = 32'h0; WriteReg_M = 5'd3;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (gotAll !== 72'h0) begin
        errors++; $display("FAIL reset_outputs got %h exp %h", gotAll, 72'h0);
      end
    end
    Rst = 0;
    tick();
    checks++;
    if (Valid_W !== 1'b1 || RetireCount !== 32'd1 || WriteData_W !== 32'h5 || RegWrite_W !== 1'b1) begin
      errors++; $display("FAIL reset_release got v=%b c=%0d d=%h rw=%b exp v=1 c=1 d=5 rw=1",
                         Valid_W, RetireCount, WriteData_W, RegWrite_W);
    end
  endtask

  task automatic test_byte_load();
    logic [31:0] tbl [4] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
    for (int i = 0; i < 4; i++) begin
      setLoad(32'h80FF_7F01, 32'h1000 + i, 2'b10, 1'b0, 5'd4);
      tick();
      checks++;
      if (WriteData_W !== tbl[i] || gotAll !== expAll) begin
        errors++; $display("FAIL byte_signed_off%0d got %h exp %h (state %h vs %h)",
                           i, WriteData_W, tbl[i], gotAll, expAll);
      end
    end
    setLoad(32'h80FF_7F01, 32'h1003, 2'b10, 1'b1, 5'd4);
    tick();
    checks++;
    if (WriteData_W !== 32'h0000_0080 || gotAll !== expAll) begin
      errors++; $display("FAIL byte_unsigned_off3 got %h exp %h", WriteData_W, 32'h80);
    end
  endtask

  task automatic test_half_word();
    setLoad(32'h8001_7FFE, 32'h2000, 2'b01, 1'b0, 5'd6);
    tick();
    checks++;
    if (WriteData_W !== 32'h0000_7FFE || AlignErr_W !== 1'b0) begin
      errors++; $display("FAIL half_off0 got %h/%b exp 00007ffe/0", WriteData_W, AlignErr_W);
    end
    setLoad(32'h8001_7FFE, 32'h2002, 2'b01, 1'b0, 5'd6);
    tick();
    checks++;
    if (WriteData_W !== 32'hFFFF_8001 || gotAll !== expAll) begin
      errors++; $display("FAIL half_off2 got %h exp ffff8001", WriteData_W);
    end
    setLoad(32'h8001_7FFE, 32'h2001, 2'b01, 1'b0, 5'd6);
    tick();
    checks++;
    if (AlignErr_W !== 1'b1 || RegWrite_W !== 1'b0 || WriteData_W !== 32'h0 || Valid_W !== 1'b1) begin
      errors++; $display("FAIL half_misalign got ae=%b rw=%b d=%h v=%b exp ae=1 rw=0 d=0 v=1",
                         AlignErr_W, RegWrite_W, WriteData_W, Valid_W);
    end
    setLoad(32'h8001_7FFE, 32'h2002, 2'b00, 1'b0, 5'd6);
    tick();
    checks++;
    if (AlignErr_W !== 1'b1 || RegWrite_W !== 1'b0) begin
      errors++; $display("FAIL word_misalign got ae=%b rw=%b exp ae=1 rw=0", AlignErr_W, RegWrite_W);
    end
    setLoad(32'h8001_7FFE, 32'h2000, 2'b00, 1'b0, 5'd6);
    tick();
    checks++;
    if (WriteData_W !== 32'h8001_7FFE || AlignErr_W !== 1'b0 || RegWrite_W !== 1'b1) begin
      errors++; $display("FAIL word_aligned got %h exp 80017ffe", WriteData_W);
    end
  endtask

  task automatic test_alu_reg0();
    setLoad(32'hDEAD_BEEF, 32'h0000_0003, 2'b11, 1'b0, 5'd7);
    MemtoReg_M = 0; MemRead_M = 0;
    tick();
    checks++;
    if (WriteData_W !== 32'h3 || RegWrite_W !== 1'b1 || AlignErr_W !== 1'b0 || WriteReg_W !== 5'd7) begin
      errors++; $display("FAIL alu_path got d=%h rw=%b ae=%b exp d=3 rw=1 ae=0", WriteData_W, RegWrite_W, AlignErr_W);
    end
    WriteReg_M = 5'd0;
    tick();
    checks++;
    if (RegWrite_W !== 1'b0 || Valid_W !== 1'b1 || gotAll !== expAll) begin
      errors++; $display("FAIL reg0_write got rw=%b v=%b exp rw=0 v=1", RegWrite_W, Valid_W);
    end
  endtask

  task automatic test_stall_flush();
    logic [71:0] snap;
    logic [31:0] cnt;
    setLoad(32'h1234_5678, 32'h3001, 2'b10, 1'b0, 5'd9);
    tick();
    snap = expAll;
    cnt  = eCount;
    checks++;
    if (WriteData_W !== 32'h56 || gotAll !== snap) begin
      errors++; $display("FAIL stall_setup got %h exp %h", gotAll, snap);
    end
    for (int i = 0; i < 3; i++) begin
      Stall = 1;
      DataMem_out = $urandom; ALUResult_M = $urandom; WriteReg_M = 5'($urandom);
      tick();
      checks++;
      if (gotAll !== snap || RetireCount !== cnt) begin
        errors++; $display("FAIL stall_hold%0d got %h exp %h", i, gotAll, snap);
      end
    end
    Stall = 1; Flush = 1;
    tick();
    checks++;
    if (Valid_W !== 1'b0 || RegWrite_W !== 1'b0 || WriteData_W !== 32'h0 ||
        WriteReg_W !== 5'd0 || AlignErr_W !== 1'b0 || RetireCount !== cnt) begin
      errors++; $display("FAIL stall_flush_bubble got %h exp count %0d all else 0", gotAll, cnt);
    end
    Stall = 0; Flush = 0;
  endtask

  task automatic test_counter_wrap();
    Rst = 1; tick(); Rst = 0;
    for (int i = 0; i < 15; i++) begin
      setLoad(32'h0, 32'h0, 2'b00, 1'b0, 5'd1);
      tick();
    end
    checks++;
    if (w4Count !== 4'hF || RetireCount !== 32'd15) begin
      errors++; $display("FAIL count_preload got %h/%0d exp f/15", w4Count, RetireCount);
    end
    tick();
    checks++;
    if (w4Count !== 4'h0 || RetireCount !== 32'd16) begin
      errors++; $display("FAIL count_wrap got %h/%0d exp 0/16", w4Count, RetireCount);
    end
  endtask

  task automatic test_random();
    logic mr;
    for (int i = 0; i < 300; i++) begin
      Rst = 0;
      Stall = ($urandom % 8) == 0;
      Flush = ($urandom % 10) == 0;
      Valid_M = ($urandom % 4) != 0;
      RegWrite_M = 1'($urandom);
      mr = 1'($urandom);
      MemtoReg_M = mr; MemRead_M = mr;
      DataWidth_M = 2'($urandom);
      LoadUnsigned_M = 1'($urandom);
      ALUResult_M = $urandom;
      DataMem_out = $urandom;
      WriteReg_M = 5'($urandom);
      tick();
      checks++;
      if (gotAll !== expAll || w4Count !== eCount[3:0]) begin
        errors++; $display("FAIL random_%0d got %h/%h exp %h/%h", i, gotAll, w4Count, expAll, eCount[3:0]);
      end
    end
  endtask

  initial begin
    {eValid, eRegWrite, eWriteReg, eWriteData, eAlign, eCount} = '0;
    test_reset();
    test_byte_load();
    test_half_word();
    test_alu_reg0();
    test_stall_flush();
    test_counter_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_wb_stage
`default_nettype wire
